counter_sequencer: RTL and testbench

COUNTER_SEQUENCER -- requirements
Module: counter_sequencer

---
 rtl/counter_seq_pkg.sv | 21 ++
 rtl/updown_count_core.sv | 32 +++
 rtl/counter_sequencer.sv | 156 +++++++++++++++
 tb/tb_counter_sequencer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared encodings for the counter sequencer: run-mode enum, FSM state enum
// and count-direction constants.
package counter_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP_ONCE   = 2'b00,
        MODE_DOWN_ONCE = 2'b01,
        MODE_PERIODIC  = 2'b10,
        MODE_PINGPONG  = 2'b11
    } mode_e;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN_UP   = 2'd1,
        RUN_DOWN = 2'd2
    } state_e;

    localparam logic CNT_UP   = 1'b0;
    localparam logic CNT_DOWN = 1'b1;

endpackage

// File: rtl/updown_count_core.sv
// N-bit loadable up/down counter with synchronous active-high reset.
// load takes priority over en; m selects direction (0 up, 1 down).
module updown_count_core #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [N-1:0] load_val,
    input  logic         en,
    input  logic         m,
    output logic [N-1:0] count
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    logic [N-1:0] r_count;

    // NOTE: clocked state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (en) begin
            r_count <= m ? (r_count - ONE) : (r_count + ONE);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/counter_sequencer.sv
// Counter sequencer: one-shot up/down, periodic and ping-pong count sequences.
// Define COUNTER_SEQ_PINGPONG_EN to enable ping-pong; otherwise mode 11 runs as periodic up.
module counter_sequencer
    import counter_seq_pkg::*;
#(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic         stop,
    input  logic [1:0]   mode,
    input  logic [N-1:0] limit,
    output logic [N-1:0] count,
    output logic         dir,
    output logic         busy,
    output logic         done
);

    localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

    state_e       r_state, w_next_state;
    mode_e        r_mode;
    logic [N-1:0] r_limit;
    logic         r_dir, r_done;

    logic [N-1:0] w_count, w_load_val;
    logic         w_load, w_en, w_m, w_dir_next, w_done_next;
    logic         w_accept, w_at_limit, w_pre_limit, w_at_zero, w_at_one;
    logic         w_cyclic, w_pp;

    assign w_accept    = (r_state == IDLE) && start && !stop;
    assign w_at_limit  = (w_count == r_limit);
    assign w_pre_limit = ((w_count + ONE) == r_limit);
    assign w_at_zero   = (w_count == '0);
    assign w_at_one    = (w_count == ONE);
    assign w_cyclic    = (r_mode == MODE_PERIODIC) || (r_mode == MODE_PINGPONG);

`ifdef COUNTER_SEQ_PINGPONG_EN
    assign w_pp = (r_mode == MODE_PINGPONG);
`else
    assign w_pp = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept)
                    w_next_state = (mode_e'(mode) == MODE_DOWN_ONCE) ? RUN_DOWN : RUN_UP;
            end
            RUN_UP: begin
                if (stop)                         w_next_state = IDLE;
                else if (w_at_limit && !w_cyclic) w_next_state = IDLE;
                else if (w_pp && w_pre_limit)     w_next_state = RUN_DOWN;
            end
            RUN_DOWN: begin
                if (stop)                         w_next_state = IDLE;
                else if (w_pp) begin
                    if (w_at_one)                 w_next_state = RUN_UP;
                end else if (w_at_zero)           w_next_state = IDLE;
            end
            default:                              w_next_state = IDLE;
        endcase
    end

    // Turning points in ping-pong update dir on the same edge the count arrives there.
    always_comb begin
        w_load      = 1'b0;
        w_load_val  = '0;
        w_en        = 1'b0;
        w_m         = CNT_UP;
        w_dir_next  = r_dir;
        w_done_next = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_load = 1'b1;
                    if (mode_e'(mode) == MODE_DOWN_ONCE) begin
                        w_load_val = limit;
                        w_dir_next = CNT_DOWN;
                    end else begin
                        w_dir_next = CNT_UP;
                    end
                end
            end
            RUN_UP: begin
                if (!stop) begin
                    if (w_at_limit) begin
                        w_done_next = 1'b1;
                        w_load      = w_cyclic;
                    end else begin
                        w_en = 1'b1;
                        if (w_pp && w_pre_limit) w_dir_next = CNT_DOWN;
                    end
                end
            end
            RUN_DOWN: begin
                if (!stop) begin
                    if (w_pp) begin
                        w_en = 1'b1;
                        w_m  = CNT_DOWN;
                        if (w_at_one) begin
                            w_dir_next  = CNT_UP;
                            w_done_next = 1'b1;
                        end
                    end else if (w_at_zero) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_en = 1'b1;
                        w_m  = CNT_DOWN;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mode  <= MODE_UP_ONCE;
            r_limit <= '0;
            r_dir   <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mode  <= mode_e'(mode);
                r_limit <= limit;
            end
            r_dir  <= w_dir_next;
            r_done <= w_done_next;
        end
    end

    updown_count_core #(.N(N)) u_core (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (w_en),
        .m        (w_m),
        .count    (w_count)
    );

    assign count = w_count;
    assign dir   = r_dir;
    assign busy  = (r_state != IDLE);
    assign done  = r_done;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: directed scenarios plus random
// stimulus against a closed-form trajectory model of each sequence.
module tb_counter_sequencer;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         reset, start, stop;
    logic [1:0]   mode;
    logic [N-1:0] limit;
    logic [N-1:0] count;
    logic         dir, busy, done;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit m_busy = 1'b0, m_dir = 1'b0, m_done = 1'b0;
    int m_count = 0, m_k = 0, m_mode = 0, m_L = 0;

`ifdef COUNTER_SEQ_PINGPONG_EN
    localparam int PP_C [7] = '{0, 1, 2, 1, 0, 1, 2};
    localparam int PP_D [7] = '{0, 0, 1, 1, 0, 0, 1};
`endif

    always #5 clk = ~clk;

    counter_sequencer #(.N(N)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .limit (limit),
        .count (count),
        .dir   (dir),
        .busy  (busy),
        .done  (done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Value of a running sequence k edges after its accepted start.
    function automatic void traj(input int md, input int L, input int k,
                                 output int c, output bit d, output bit dn);
        int p;
        c = 0; d = 1'b0; dn = 1'b0;
        case (md)
            0: c = k;
            1: begin c = L - k; d = 1'b1; end
            2: begin c = k % (L + 1); dn = (k > 0) && (c == 0); end
            default: begin
                if (L == 0) begin
                    dn = (k > 0);
                end else begin
                    p  = k % (2 * L);
                    c  = (p <= L) ? p : 2 * L - p;
                    d  = (p >= L);
                    dn = (k > 0) && (p == 0);
                end
            end
        endcase
    endfunction

    task automatic model_update(input logic rst, input logic st, input logic sp,
                                input logic [1:0] md, input logic [N-1:0] lim);
        int c; bit d, dn; int eff;
`ifdef COUNTER_SEQ_PINGPONG_EN
        eff = int'(md);
`else
        eff = (md == 2'b11) ? 2 : int'(md);
`endif
        if (rst) begin
            m_busy = 0; m_count = 0; m_dir = 0; m_done = 0;
        end else if (!m_busy) begin
            m_done = 0;
            if (st && !sp) begin
                m_busy = 1; m_k = 0; m_mode = eff; m_L = int'(lim);
                traj(m_mode, m_L, 0, c, d, dn);
                m_count = c; m_dir = d;
            end
        end else if (sp) begin
            m_busy = 0; m_done = 0;
        end else begin
            m_k++;
            if (m_mode < 2 && m_k == m_L + 1) begin
                m_busy = 0; m_done = 1;
            end else begin
                traj(m_mode, m_L, m_k, c, d, dn);
                m_count = c; m_dir = d; m_done = dn;
            end
        end
    endtask

    task automatic step(input string tag, input logic rst, input logic st, input logic sp,
                        input logic [1:0] md, input logic [N-1:0] lim);
        reset = rst; start = st; stop = sp; mode = md; limit = lim;
        @(posedge clk);
        model_update(rst, st, sp, md, lim);
        #1;
        chk({tag, ".count"}, 32'(count), 32'(m_count));
        chk({tag, ".dir"},   32'(dir),   32'(m_dir));
        chk({tag, ".busy"},  32'(busy),  32'(m_busy));
        chk({tag, ".done"},  32'(done),  32'(m_done));
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 1'b0, 1'b0, 2'b00, '0);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'b00; limit = '0;

        step("reset", 1'b1, 1'b0, 1'b0, 2'b00, '0);
        step("reset", 1'b1, 1'b0, 1'b0, 2'b00, '0);
        chk("reset_count", 32'(count), 0);
        chk("reset_busy",  32'(busy),  0);

        // One-shot up, L=5
        step("up5", 1'b0, 1'b1, 1'b0, 2'b00, 4'd5);
        chk("up5_c", 32'(count), 0);
        chk("up5_busy", 32'(busy), 1);
        for (int i = 1; i <= 5; i++) begin
            idle("up5");
            chk("up5_c", 32'(count), 32'(i));
        end
        idle("up5_end");
        chk("up5_done", 32'(done), 1);
        chk("up5_idle", 32'(busy), 0);
        chk("up5_hold", 32'(count), 5);
        idle("up5_after");
        chk("up5_done_clr", 32'(done), 0);

        // One-shot down, L=3
        step("dn3", 1'b0, 1'b1, 1'b0, 2'b01, 4'd3);
        for (int i = 0; i <= 3; i++) begin
            if (i > 0) idle("dn3");
            chk("dn3_c", 32'(count), 32'(3 - i));
            chk("dn3_dir", 32'(dir), 1);
        end
        idle("dn3_end");
        chk("dn3_done", 32'(done), 1);
        idle("dn3_after");
        chk("dn3_dir_hold", 32'(dir), 1);

        // Periodic, L=2
        step("per2", 1'b0, 1'b1, 1'b0, 2'b10, 4'd2);
        for (int i = 0; i < 9; i++) begin
            if (i > 0) idle("per2");
            chk("per2_c", 32'(count), 32'(i % 3));
            chk("per2_done", 32'(done), 32'(i == 3 || i == 6));
        end
        step("per2_stop", 1'b0, 1'b0, 1'b1, 2'b00, '0);

        // Ping-pong (or periodic when disabled), L=2
        step("pp2", 1'b0, 1'b1, 1'b0, 2'b11, 4'd2);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) idle("pp2");
`ifdef COUNTER_SEQ_PINGPONG_EN
            chk("pp2_c", 32'(count), 32'(PP_C[i]));
            chk("pp2_dir", 32'(dir), 32'(PP_D[i]));
`else
            chk("pp2_c", 32'(count), 32'(i % 3));
            chk("pp2_dir", 32'(dir), 0);
`endif
        end
        step("pp2_stop", 1'b0, 1'b0, 1'b1, 2'b00, '0);

        // Stop mid-run, then start with stop in the same cycle
        step("stop7", 1'b0, 1'b1, 1'b0, 2'b00, 4'd7);
        for (int i = 0; i < 3; i++) idle("stop7");
        step("stop7_abort", 1'b0, 1'b0, 1'b1, 2'b00, '0);
        chk("stop7_busy", 32'(busy), 0);
        chk("stop7_hold", 32'(count), 3);
        chk("stop7_nodone", 32'(done), 0);
        step("start_stop", 1'b0, 1'b1, 1'b1, 2'b00, 4'd4);
        chk("start_stop_busy", 32'(busy), 0);

        // Reset mid-run in periodic mode, start concurrent with reset
        step("rst5", 1'b0, 1'b1, 1'b0, 2'b10, 4'd5);
        for (int i = 0; i < 3; i++) idle("rst5");
        step("rst5_hit", 1'b1, 1'b0, 1'b0, 2'b00, '0);
        chk("rst5_count", 32'(count), 0);
        chk("rst5_busy", 32'(busy), 0);
        chk("rst5_done", 32'(done), 0);
        step("rst_start", 1'b1, 1'b1, 1'b0, 2'b10, 4'd5);
        chk("rst_start_busy", 32'(busy), 0);

        // L=0 boundaries
        step("up0", 1'b0, 1'b1, 1'b0, 2'b00, 4'd0);
        idle("up0");
        chk("up0_done", 32'(done), 1);
        chk("up0_busy", 32'(busy), 0);
        step("per0", 1'b0, 1'b1, 1'b0, 2'b10, 4'd0);
        for (int i = 0; i < 3; i++) begin
            idle("per0");
            chk("per0_done", 32'(done), 1);
        end
        step("per0_stop", 1'b0, 1'b0, 1'b1, 2'b00, '0);

        // Random phase
        for (int i = 0; i < 800; i++) begin
            step("rand",
                 ($urandom_range(99) < 1),
                 ($urandom_range(99) < 30),
                 ($urandom_range(99) < 4),
                 2'($urandom_range(3)),
                 N'($urandom_range(15)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
